// File: rtl/crc_arbiter.sv
// Two-requester front end for a shared CRC engine. One frame in flight at a time:
// round-robin grant, registered word forwarding, then wait for the engine result
// (or a timeout) and return it to the granted requester.
module crc_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] req_data_i,
    input  logic [63:0] req_poly_i,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req_last_i,
    output logic [1:0]  req_ready_o,
    output logic [31:0] eng_data_o,
    output logic [31:0] eng_poly_o,
    output logic        eng_valid_o,
    output logic        eng_last_o,
    input  logic [31:0] eng_crc_i,
    input  logic        eng_crc_valid_i,
    output logic [31:0] rsp_crc_o,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StWaitCrc, StResp} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_grant;
    logic            r_last_grant;
    logic            r_poly_pend;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_eng_data;
    logic [31:0]     r_eng_poly;
    logic            r_eng_valid;
    logic            r_eng_last;
    logic [31:0]     r_rsp_crc;
    logic            r_rsp_id;
    logic            r_rsp_timeout;

    logic [31:0]     w_data;
    logic [31:0]     w_poly;
    logic            w_last;
    logic            w_accept;
    logic            w_timeout;
    logic            w_new_grant;

    assign w_data      = r_grant ? req_data_i[63:32] : req_data_i[31:0];
    assign w_poly      = r_grant ? req_poly_i[63:32] : req_poly_i[31:0];
    assign w_last      = req_last_i[r_grant];
    assign w_accept    = (r_state == StStream) && req_valid_i[r_grant];
    assign w_timeout   = (r_cnt == CntW'(TIMEOUT_CYC - 1));
    // On a tie the requester that was not served last wins.
    assign w_new_grant = (req_valid_i == 2'b11) ? ~r_last_grant : req_valid_i[1];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        req_ready_o  = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (|req_valid_i) w_state_next = StStream;
            end
            StStream: begin
                req_ready_o = r_grant ? 2'b10 : 2'b01;
                if (w_accept && w_last) w_state_next = StWaitCrc;
            end
            StWaitCrc: begin
                if (eng_crc_valid_i || w_timeout) w_state_next = StResp;
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Grant, word forwarding, wait counter and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_poly_pend   <= 1'b0;
            r_cnt         <= '0;
            r_eng_data    <= '0;
            r_eng_poly    <= '0;
            r_eng_valid   <= 1'b0;
            r_eng_last    <= 1'b0;
            r_rsp_crc     <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_eng_valid <= w_accept;
            if (r_state == StIdle && |req_valid_i) begin
                r_grant     <= w_new_grant;
                r_poly_pend <= 1'b1;
            end
            if (w_accept) begin
                r_eng_data <= w_data;
                r_eng_last <= w_last;
                // Polynomial is taken from the first word only and held for the frame.
                if (r_poly_pend) begin
                    r_eng_poly  <= w_poly;
                    r_poly_pend <= 1'b0;
                end
            end
            if (r_state == StWaitCrc) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            // A real result beats a timeout landing in the same cycle.
            if (r_state == StWaitCrc) begin
                if (eng_crc_valid_i) begin
                    r_rsp_crc     <= eng_crc_i;
                    r_rsp_timeout <= 1'b0;
                    r_rsp_id      <= r_grant;
                end else if (w_timeout) begin
                    r_rsp_crc     <= '0;
                    r_rsp_timeout <= 1'b1;
                    r_rsp_id      <= r_grant;
                end
            end
            if (r_state == StResp) r_last_grant <= r_grant;
        end
    end

    assign eng_data_o    = r_eng_data;
    assign eng_poly_o    = r_eng_poly;
    assign eng_valid_o   = r_eng_valid;
    assign eng_last_o    = r_eng_last;
    assign rsp_crc_o     = r_rsp_crc;
    assign rsp_id_o      = r_rsp_id;
    assign rsp_timeout_o = r_rsp_timeout;
    assign rsp_valid_o   = (r_state == StResp);
    assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_crc_arbiter.sv
// Scoreboard bench for crc_arbiter: frames are queued per requester, the expected engine
// word stream and grant order are derived from the round-robin rule at enqueue time, and a
// behavioural engine decides each frame's result latency, pushing the expected response.
`timescale 1ns/1ps
module tb_crc_arbiter;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] req_data_i;
    logic [63:0] req_poly_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_o;
    logic [31:0] eng_data_o;
    logic [31:0] eng_poly_o;
    logic        eng_valid_o;
    logic        eng_last_o;
    logic [31:0] eng_crc_i;
    logic        eng_crc_valid_i;
    logic [31:0] rsp_crc_o;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    crc_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_data_i(req_data_i), .req_poly_i(req_poly_i),
        .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_ready_o(req_ready_o),
        .eng_data_o(eng_data_o), .eng_poly_o(eng_poly_o), .eng_valid_o(eng_valid_o),
        .eng_last_o(eng_last_o), .eng_crc_i(eng_crc_i), .eng_crc_valid_i(eng_crc_valid_i),
        .rsp_crc_o(rsp_crc_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  gap;
        logic        last;
        logic [31:0] poly;
        logic [31:0] data;
    } drv_t;
    typedef struct packed {
        logic        id;
        logic        last;
        logic [31:0] poly;
        logic [31:0] data;
    } word_t;
    typedef struct packed {
        logic        id;
        logic [31:0] crc;
        logic        tmo;
        logic [31:0] cyc;
    } rsp_t;

    drv_t  wq[2][$];
    word_t stg[2][$];
    word_t ew_q[$];
    logic  rid_q[$];
    rsp_t  exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          nfwd = 0;
    int          f_first = 0;
    int          f_last = 0;
    logic        m_last = 1'b1;
    int          eng_mode = 0;      // 0 random, 1 fixed value, 2 never answers
    logic [31:0] eng_fix = '0;
    bit          spur_all = 1'b0;
    int          spur_req = 0;
    bit          eng_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s actual=%s required=none (cycle %0d)", name, what, cyc);
    endtask

    // Requester driver: presents queued words, pops on acceptance, inserts per-word gaps.
    initial begin : driver
        logic [1:0] acc;
        int         gap[2];
        drv_t       e;
        gap = '{0, 0};
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        req_poly_i  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid_i & req_ready_o;
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (rst_i) begin
                    gap[n] = 0;
                end else if (acc[n] && wq[n].size() > 0) begin
                    e = wq[n].pop_front();
                    gap[n] = int'(e.gap);
                end
                if (gap[n] > 0) begin
                    req_valid_i[n] = 1'b0;
                    gap[n]--;
                end else if (wq[n].size() > 0) begin
                    e = wq[n][0];
                    req_valid_i[n]         = 1'b1;
                    req_last_i[n]          = e.last;
                    req_data_i[32*n +: 32] = e.data;
                    req_poly_i[32*n +: 32] = e.poly;
                end else begin
                    req_valid_i[n] = 1'b0;
                    req_last_i[n]  = 1'b0;
                end
            end
        end
    end

    // Engine model: on the last word picks a latency (or silence) and records the response.
    initial begin : engine
        int          pend_k;
        logic [31:0] pend_crc;
        int          k;
        int          sel;
        int          spur_done;
        logic [31:0] val;
        logic        id;
        rsp_t        r;
        spur_done = 0;
        pend_k = 0;
        pend_crc = '0;
        eng_crc_valid_i = 1'b0;
        eng_crc_i = '0;
        forever begin
            @(negedge clk);
            eng_crc_valid_i = 1'b0;
            if (rst_i) begin
                eng_pend = 1'b0;
            end else if (spur_done != spur_req) begin
                spur_done = spur_req;
                eng_crc_valid_i = 1'b1;
                eng_crc_i = $urandom;
            end else if (eng_pend) begin
                pend_k--;
                if (pend_k == 0) begin
                    eng_crc_valid_i = 1'b1;
                    eng_crc_i = pend_crc;
                    eng_pend = 1'b0;
                end
            end else if (eng_valid_o && !eng_last_o && (spur_all || $urandom_range(0, 3) == 0)) begin
                eng_crc_valid_i = 1'b1;
                eng_crc_i = $urandom;
            end
            if (!rst_i && eng_valid_o && eng_last_o) begin
                id = (rid_q.size() > 0) ? rid_q.pop_front() : 1'b0;
                sel = $urandom_range(0, 19);
                if (eng_mode == 2) k = 1000;
                else if (eng_mode == 1 || sel < 14) k = $urandom_range(0, TO - 1);
                else if (sel < 17) k = 1000;
                else k = TO + $urandom_range(0, 1);
                val = (eng_mode == 1) ? eng_fix : $urandom;
                r.id = id;
                if (k < TO) begin
                    r.crc = val;
                    r.tmo = 1'b0;
                    r.cyc = 32'(cyc + k + 1);
                end else begin
                    r.crc = '0;
                    r.tmo = 1'b1;
                    r.cyc = 32'(cyc + TO);
                end
                exp_q.push_back(r);
                if (k == 0) begin
                    eng_crc_valid_i = 1'b1;
                    eng_crc_i = val;
                end else if (k < 1000) begin
                    eng_pend = 1'b1;
                    pend_k = k;
                    pend_crc = val;
                end
            end
        end
    end

    // Engine-side monitor: grant exclusivity and forwarded word stream.
    initial begin : word_mon
        word_t e;
        bit    first;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_i) first = 1'b1;
            if (req_ready_o != 2'b00) begin
                if (ew_q.size() == 0) fail_now("ready_unexpected", $sformatf("%b", req_ready_o));
                else chk("ready_grant", req_ready_o, ew_q[0].id ? 2'b10 : 2'b01);
            end
            if (eng_valid_o) begin
                if (ew_q.size() == 0) begin
                    fail_now("eng_word_unexpected", $sformatf("%h", eng_data_o));
                end else begin
                    e = ew_q.pop_front();
                    chk("eng_word", {eng_last_o, eng_poly_o, eng_data_o}, {e.last, e.poly, e.data});
                    nfwd++;
                    if (first) f_first = cyc;
                    if (e.last) f_last = cyc;
                    first = e.last;
                end
            end
        end
    end

    // Response monitor: one-cycle strobe, contents, timing, and hold afterwards.
    initial begin : rsp_mon
        rsp_t        e;
        bit          hold;
        logic [33:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("rsp_hold", {rsp_id_o, rsp_timeout_o, rsp_crc_o}, held);
                hold = 1'b0;
            end
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected", $sformatf("id%0d crc%h", rsp_id_o, rsp_crc_o));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id_o, e.id);
                    chk("rsp_crc", rsp_crc_o, e.crc);
                    chk("rsp_timeout", rsp_timeout_o, e.tmo);
                    chk("rsp_cycle", cyc, e.cyc);
                end
                held = {rsp_id_o, rsp_timeout_o, rsp_crc_o};
                hold = 1'b1;
            end
        end
    end

    task automatic push_word(input int n, input logic [31:0] d, input logic [31:0] p,
                             input logic last, input logic [1:0] gap);
        drv_t  x;
        word_t w;
        x.gap  = last ? 2'd0 : gap;
        x.last = last;
        x.poly = p;
        x.data = d;
        wq[n].push_back(x);
        w.id   = 1'b0;
        w.last = last;
        w.poly = p;
        w.data = d;
        stg[n].push_back(w);
    endtask

    // Orders staged frames by round robin: alternate while both wait, else the lone one.
    task automatic commit();
        word_t w;
        int    win;
        while (stg[0].size() > 0 || stg[1].size() > 0) begin
            if (stg[0].size() > 0 && stg[1].size() > 0) win = m_last ? 0 : 1;
            else win = (stg[0].size() > 0) ? 0 : 1;
            m_last = (win == 1);
            rid_q.push_back(win == 1);
            do begin
                w = stg[win].pop_front();
                w.id = (win == 1);
                ew_q.push_back(w);
            end while (!w.last);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((wq[0].size() > 0 || wq[1].size() > 0 || ew_q.size() > 0 || rid_q.size() > 0 ||
                exp_q.size() > 0 || eng_pend) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) fail_now({name, "_drain_timeout"}, "pending");
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        wq[0].delete();
        wq[1].delete();
        stg[0].delete();
        stg[1].delete();
        ew_q.delete();
        rid_q.delete();
        exp_q.delete();
        m_last = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {eng_data_o, eng_poly_o, rsp_crc_o, req_ready_o, eng_valid_o,
                              eng_last_o, rsp_valid_o, rsp_id_o, rsp_timeout_o, busy_o}, '0);
        repeat (ncyc - 1) @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin : main
        logic [255:0] vec;
        int           base;
        int           t;
        int           cnt[2];
        int           len;
        rst_i = 1'b1;
        @(negedge clk);
        do_reset(2);

        // Engine strobe while idle is ignored.
        spur_req++;
        repeat (4) @(negedge clk);
        chk("idle_spur_busy", busy_o, 1'b0);

        // Directed known-answer frame from requester 0.
        vec = 256'h1234567890ABCDEF;
        eng_mode = 1;
        eng_fix = 32'h46FD7AA9;
        for (int i = 0; i < 8; i++) push_word(0, vec[32*i +: 32], 32'h04C11DB7, i == 7, 2'd0);
        commit();
        wait_done("kat");

        // Gaps after words 2 and 5, engine strobes during streaming.
        spur_all = 1'b1;
        eng_mode = 0;
        for (int i = 0; i < 8; i++)
            push_word(0, $urandom, 32'hEDB88320, i == 7, (i == 1 || i == 4) ? 2'd2 : 2'd0);
        commit();
        wait_done("gaps");
        chk("gap_span", f_last - f_first, 11);
        spur_all = 1'b0;

        // Single-word frame, engine silent: timeout response.
        eng_mode = 2;
        push_word(1, $urandom, 32'h1EDC6F41, 1'b1, 2'd0);
        commit();
        wait_done("timeout");

        // Both requesters busy from reset: grant order 0,1,0.
        eng_mode = 0;
        do_reset(2);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++) push_word(0, $urandom, 32'hA0000001, i == 2, 2'd0);
        for (int i = 0; i < 4; i++) push_word(1, $urandom, 32'hB0000002, i == 3, 2'd0);
        commit();
        wait_done("order");

        // Randomized traffic.
        for (int r = 0; r < 8; r++) begin
            cnt[0] = $urandom_range(0, 3);
            cnt[1] = $urandom_range(0, 3);
            if (cnt[0] == 0 && cnt[1] == 0) cnt[0] = 1;
            for (int n = 0; n < 2; n++) begin
                for (int f = 0; f < cnt[n]; f++) begin
                    len = $urandom_range(1, 6);
                    vec[31:0] = $urandom;
                    for (int i = 0; i < len; i++)
                        push_word(n, $urandom, vec[31:0], i == len - 1,
                                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0);
                end
            end
            commit();
            wait_done("random");
        end

        // Reset mid-frame abandons it; the next frame starts cleanly.
        base = nfwd;
        for (int i = 0; i < 8; i++) push_word(0, $urandom, 32'h04C11DB7, i == 7, 2'd0);
        commit();
        t = 0;
        while (nfwd < base + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("midframe_wait", "stalled");
        do_reset(2);
        repeat (3) @(negedge clk);
        chk("after_reset_idle", {busy_o, rsp_valid_o}, 2'b00);
        eng_mode = 1;
        eng_fix = 32'hA008D0FB;
        for (int i = 0; i < 8; i++) push_word(1, 32'h0, 32'h04C11DB7, i == 7, 2'd0);
        commit();
        wait_done("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
